clk_ratio_meter: RTL
====================

CLK_RATIO_METER -- requirements
Module: clk_ratio_meter

Interface
REQ-001 Parameter TIMEOUT, default 4200, is the number of inClk cycles without a measClk rising edge before loss is declared; legal range 4097..8191.
REQ-002 Parameter LOCK_COUNT, default 3, is the number of consecutive equal ratios required before valid; legal range 1..15.
REQ-003 Port inClk, input, 1 bit, is the single clock; all state is on posedge.
REQ-004 Port rst, input, 1 bit, is the reset: asynchronous, active-high.
REQ-005 Port measClk, input, 1 bit, is the clock under measurement (nominally inClk/2^n) and is treated as asynchronous.
REQ-006 Port ratio, output, 4 bits, is the measured exponent n (period = 2^n inClk cycles).
REQ-007 Port valid, output, 1 bit, indicates ratio is locked and trustworthy.
REQ-008 Port err_ratio, output, 1 bit, indicates the last period was not a power of two in 2..2048.
REQ-009 Port no_clk, output, 1 bit, indicates no measClk edge was seen within TIMEOUT cycles.

Function
REQ-010 measClk SHALL pass a 2-flop synchronizer; an edge pulse SHALL be asserted for one cycle when sync=1 and the previous sync=0.
REQ-011 Period counter cnt (13 bits) SHALL load 1 in an edge cycle and increment in every non-edge cycle; at the next edge, period P = cnt.
REQ-012 The FSM SHALL have states S_SEEK (no reference edge yet) and S_MEAS (reference edge held); reset state is S_SEEK.
REQ-013 S_SEEK SHALL move to S_MEAS on an edge pulse with no ratio evaluation, load cnt=1, and clear no_clk.
REQ-014 On an edge in S_MEAS: if P = 2^k with 1<=k<=11, SHALL compute candidate n=k and clear err_ratio; otherwise SHALL set err_ratio, clear valid, and zero the match count.
REQ-015 Match counter: a candidate equal to the previous candidate SHALL increment it, saturating at LOCK_COUNT; a different candidate SHALL set it to 1.
REQ-016 valid SHALL be 1 exactly when match count = LOCK_COUNT; ratio SHALL be updated only when valid rises or stays high.
REQ-017 Latency: ratio, valid and err_ratio SHALL update in the cycle after the edge pulse that completed the period (registered).
REQ-018 When cnt = TIMEOUT in a non-edge cycle, in either state, the block SHALL set no_clk, clear valid and the match count, keep err_ratio, enter S_SEEK, and hold cnt at TIMEOUT (no wrap).
REQ-019 On a ratio change while locked, valid SHALL fall after the first differing period and re-assert after LOCK_COUNT equal new periods.
REQ-020 n=0 (measClk = inClk) is unmeasurable and SHALL resolve to err_ratio or no_clk, never valid.

Reset
REQ-021 Asserting rst, including mid-measurement, SHALL immediately give ratio=0, valid=0, err_ratio=0, no_clk=0, cnt=0, match=0, synchronizer=0, state S_SEEK.
REQ-022 After rst deasserts, the first edge pulse SHALL be treated as a reference only (REQ-013).

Configuration
REQ-023 Macro CLK_RATIO_METER_LOCK_EN: when defined, the lock behaviour of REQ-015/016 applies; when undefined, the match counter SHALL be omitted and valid SHALL assert after every single good period, with LOCK_COUNT ignored.

Structure
REQ-024 Package clk_ratio_pkg SHALL hold the FSM state typedef, CNT_W=13, and MAX_N=11.
REQ-025 Sub-module clk_edge_sync SHALL hold the 2-flop synchronizer plus rising-edge detector, with ports inClk, rst, d, and rise.

Verification
REQ-026 measClk = inClk/8, LOCK_COUNT=3, macro defined -> ratio=3 and valid=1 one cycle after the 4th edge pulse; no_clk=0 and err_ratio=0.
REQ-027 measClk = inClk/2048 -> ratio=11 and valid=1; measClk = inClk/2 -> ratio=1 and valid=1.
REQ-028 measClk with a period of 12 cycles -> err_ratio=1 and valid=0 one cycle after the 2nd edge; then switch to /16 -> err_ratio=0 and ratio=4 after 3 good periods.
REQ-029 Lock at /32, then hold measClk low -> no_clk=1 and valid=0 exactly TIMEOUT cycles after the last edge pulse; restart at /4 -> no_clk clears at the first edge and ratio=2 after 3 good periods.
REQ-030 Lock at /16, switch to /64 -> valid falls after the first 64-cycle period and re-asserts with ratio=6; rst pulse mid-period -> all outputs 0 asynchronously.
REQ-031 Macro undefined, /8 -> valid=1 and ratio=3 one cycle after the 2nd edge pulse.

Source files
------------

// File: rtl/clk_ratio_pkg.sv
// rtl/clk_ratio_pkg.sv - shared FSM type and constants for the clock ratio meter
package clk_ratio_pkg;

  localparam int CNT_W = 13;
  localparam int MAX_N = 11;

  typedef enum logic {
    S_SEEK = 1'b0,
    S_MEAS = 1'b1
  } state_e;

  // Exponent k when p == 2^k with 1 <= k <= MAX_N; 0 flags an unusable period.
  function automatic logic [3:0] pow2_exp(input logic [CNT_W-1:0] p);
    logic [3:0] k;
    k = 4'd0;
    for (int i = 1; i <= MAX_N; i++) begin
      if (p == (CNT_W'(1) << i)) k = 4'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// rtl/clk_edge_sync.sv - two-flop synchronizer with rising-edge pulse for an async input
module clk_edge_sync (
  input  logic inClk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge inClk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// rtl/clk_ratio_meter.sv - measures measClk period as a power-of-two ratio of inClk
// Lock filtering over LOCK_COUNT equal periods is enabled by CLK_RATIO_METER_LOCK_EN.
module clk_ratio_meter
  import clk_ratio_pkg::*;
#(
  parameter int TIMEOUT    = 4200,
  parameter int LOCK_COUNT = 3
) (
  input  logic       inClk,
  input  logic       rst,
  input  logic       measClk,
  output logic [3:0] ratio,
  output logic       valid,
  output logic       err_ratio,
  output logic       no_clk
);

  if (TIMEOUT < 4097 || TIMEOUT > 8191 || LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_param_check
    $error("clk_ratio_meter: TIMEOUT or LOCK_COUNT out of range");
  end

  logic             edge_pulse;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       ratio_q;
  logic             valid_q;
  logic             err_q;
  logic             no_clk_q;
  logic [3:0]       k_d;
  logic             timeout_d;
  logic             good_d;
  logic             bad_d;
  logic             lock_d;

  clk_edge_sync u_sync (
    .inClk (inClk),
    .rst   (rst),
    .d     (measClk),
    .rise  (edge_pulse)
  );

  assign k_d       = pow2_exp(cnt_q);
  assign timeout_d = !edge_pulse && (cnt_q == CNT_W'(TIMEOUT));
  assign good_d    = edge_pulse && (state_q == S_MEAS) && (k_d != 4'd0);
  assign bad_d     = edge_pulse && (state_q == S_MEAS) && (k_d == 4'd0);

`ifdef CLK_RATIO_METER_LOCK_EN
  logic [3:0] cand_q;
  logic [3:0] match_q;
  logic [3:0] match_d;

  always_comb begin
    match_d = 4'd1;
    if (k_d == cand_q) begin
      match_d = (match_q >= 4'(LOCK_COUNT)) ? 4'(LOCK_COUNT) : match_q + 4'd1;
    end
  end

  always_ff @(posedge inClk or posedge rst) begin
    if (rst) begin
      cand_q  <= 4'd0;
      match_q <= 4'd0;
    end else if (good_d) begin
      cand_q  <= k_d;
      match_q <= match_d;
    end else if (bad_d || timeout_d) begin
      match_q <= 4'd0;
    end
  end

  assign lock_d = (match_d == 4'(LOCK_COUNT));
`else
  assign lock_d = 1'b1;
`endif

  // cnt holds at TIMEOUT after loss so the flag stays asserted until the next edge.
  always_ff @(posedge inClk or posedge rst) begin
    if (rst) begin
      state_q  <= S_SEEK;
      cnt_q    <= '0;
      ratio_q  <= 4'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      no_clk_q <= 1'b0;
    end else if (edge_pulse) begin
      cnt_q <= CNT_W'(1);
      if (state_q == S_SEEK) begin
        state_q  <= S_MEAS;
        no_clk_q <= 1'b0;
      end else if (good_d) begin
        err_q   <= 1'b0;
        valid_q <= lock_d;
        if (lock_d) ratio_q <= k_d;
      end else begin
        err_q   <= 1'b1;
        valid_q <= 1'b0;
      end
    end else if (timeout_d) begin
      state_q  <= S_SEEK;
      no_clk_q <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ratio     = ratio_q;
  assign valid     = valid_q;
  assign err_ratio = err_q;
  assign no_clk    = no_clk_q;

endmodule
